// File: rtl/cnn_inference_core_if.sv
// ============================================================================
// Module  : cnn_inference_core_if
// Brief   : Start/done handshake and operand bus of the CNN inference core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnn_inference_core_if #(
    parameter int DATA_W = 32
);
    logic                       start;
    logic [64*DATA_W-1:0]       img_flat;
    logic [9*DATA_W-1:0]        kern_flat;
    logic [9*DATA_W-1:0]        fcw_flat;
    logic [DATA_W-1:0]          fc_bias;
    logic                       busy;
    logic                       done;
    logic signed [DATA_W-1:0]   result;

    modport master (
        output start, img_flat, kern_flat, fcw_flat, fc_bias,
        input  busy, done, result
    );

    modport slave (
        input  start, img_flat, kern_flat, fcw_flat, fc_bias,
        output busy, done, result
    );
endinterface

`default_nettype wire

// File: rtl/cnn_inference_core.sv
// ============================================================================
// Module  : cnn_inference_core
// Brief   : 8x8 image -> 3x3 conv -> 2x2 max pool -> 9-input FC neuron -> scalar.
//           Optional macro CNN_CORE_RELU_EN clamps negative results to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_inference_core #(
    parameter int DATA_W = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cnn_inference_core_if.slave     bus
);
    localparam int c_ACC_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_FC   = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    logic [5:0] r_idx;
    logic [2:0] r_row;
    logic [2:0] r_col;

    logic signed [DATA_W-1:0]  r_img  [64];
    logic signed [DATA_W-1:0]  r_kern [9];
    logic signed [DATA_W-1:0]  r_fcw  [9];
    logic signed [DATA_W-1:0]  r_bias;
    logic signed [DATA_W-1:0]  r_conv [36];
    logic signed [DATA_W-1:0]  r_pool [9];

    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [DATA_W-1:0]  r_result;
    logic                      r_done;
    logic                      r_busy;

    logic signed [c_ACC_W-1:0] w_conv_acc;
    logic [5:0]                w_pool_base;
    logic signed [DATA_W-1:0]  w_p00, w_p01, w_p10, w_p11;
    logic signed [DATA_W-1:0]  w_max_top, w_max_bot, w_pool_max;
    logic signed [c_ACC_W-1:0] w_fc_prod;
    logic signed [c_ACC_W-1:0] w_fc_sum;
    logic signed [DATA_W-1:0]  w_fc_word;
    logic signed [DATA_W-1:0]  w_result_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV:  if (r_idx == 6'd35) w_state_nxt = S_POOL;
            S_POOL:  if (r_idx == 6'd8)  w_state_nxt = S_FC;
            S_FC:    if (r_idx == 6'd8)  w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Correlation window anchored at (r_row, r_col); products kept at full width.
    always_comb begin
        w_conv_acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_conv_acc = w_conv_acc
                    + c_ACC_W'(r_img[6'((int'(r_row) + i) * 8 + int'(r_col) + j)])
                    * c_ACC_W'(r_kern[4'(i * 3 + j)]);
            end
        end
    end

    always_comb begin
        w_pool_base = 6'(int'(r_row) * 12 + int'(r_col) * 2);
        w_p00       = r_conv[w_pool_base];
        w_p01       = r_conv[w_pool_base + 6'd1];
        w_p10       = r_conv[w_pool_base + 6'd6];
        w_p11       = r_conv[w_pool_base + 6'd7];
        w_max_top   = (w_p00 > w_p01) ? w_p00 : w_p01;
        w_max_bot   = (w_p10 > w_p11) ? w_p10 : w_p11;
        w_pool_max  = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
    end

    always_comb begin
        w_fc_prod = c_ACC_W'(r_pool[r_idx[3:0]]) * c_ACC_W'(r_fcw[r_idx[3:0]]);
        w_fc_sum  = r_acc + c_ACC_W'(r_bias);
        w_fc_word = w_fc_sum[DATA_W-1:0];
`ifdef CNN_CORE_RELU_EN
        w_result_nxt = w_fc_word[DATA_W-1] ? '0 : w_fc_word;
`else
        w_result_nxt = w_fc_word;
`endif
    end

    // Operand capture and intermediate arrays carry no reset; they are rewritten every run.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int n = 0; n < 64; n++) begin
                r_img[n] <= bus.img_flat[n*DATA_W +: DATA_W];
            end
            for (int k = 0; k < 9; k++) begin
                r_kern[k] <= bus.kern_flat[k*DATA_W +: DATA_W];
                r_fcw[k]  <= bus.fcw_flat[k*DATA_W +: DATA_W];
            end
            r_bias <= bus.fc_bias;
        end
        if (r_state == S_CONV) begin
            r_conv[r_idx] <= w_conv_acc[DATA_W-1:0];
        end
        if (r_state == S_POOL) begin
            r_pool[r_idx[3:0]] <= w_pool_max;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= (r_state == S_OUT);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_CONV: begin
                    if (r_idx == 6'd35) begin
                        r_idx <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                        if (r_col == 3'd5) begin
                            r_col <= '0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                S_POOL: begin
                    if (r_idx == 6'd8) begin
                        r_idx <= '0;
                        r_row <= '0;
                        r_col <= '0;
                        r_acc <= '0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                        if (r_col == 3'd2) begin
                            r_col <= '0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                S_FC: begin
                    r_acc <= r_acc + w_fc_prod;
                    r_idx <= (r_idx == 6'd8) ? 6'd0 : r_idx + 6'd1;
                end
                S_OUT: begin
                    r_result <= w_result_nxt;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_cnn_inference_core.sv
// ============================================================================
// Module  : tb_cnn_inference_core
// Brief   : Directed self-checking bench for cnn_inference_core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_inference_core;
    localparam int c_DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_inference_core_if #(.DATA_W(c_DW)) intf();

    cnn_inference_core #(.DATA_W(c_DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int iv, input int kv, input int fv, input int bv);
        for (int n = 0; n < 64; n++) intf.img_flat[n*c_DW +: c_DW] = iv;
        for (int k = 0; k < 9; k++) begin
            intf.kern_flat[k*c_DW +: c_DW] = kv;
            intf.fcw_flat[k*c_DW +: c_DW]  = fv;
        end
        intf.fc_bias = bv;
    endtask

    // Pulses start, watches for done within a bounded window, checks latency and value.
    task automatic run_op(input string tag, input logic signed [63:0] exp, input bit disturb);
        int k;
        int done_at;
        k       = 0;
        done_at = 0;
        intf.start = 1'b1;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        check_val({tag, ":busy_after_start"}, 64'(intf.busy), 64'sd1);
        while (done_at == 0 && k < 80) begin
            if (disturb) begin
                intf.start = (k == 9 || k == 29);
                if (k == 1) set_all(5, 3, 2, 7);
            end
            @(posedge clk);
            #1;
            k++;
            if (intf.done) done_at = k;
        end
        intf.start = 1'b0;
        check_val({tag, ":done_edge"}, 64'(done_at), 64'sd55);
        check_val({tag, ":result"}, 64'(intf.result), exp);
        check_val({tag, ":busy_in_done"}, 64'(intf.busy), 64'sd1);
        @(posedge clk);
        #1;
        check_val({tag, ":done_low"}, 64'(intf.done), 64'sd0);
        check_val({tag, ":busy_low"}, 64'(intf.busy), 64'sd0);
        check_val({tag, ":result_held"}, 64'(intf.result), exp);
    endtask

    initial begin
        logic signed [63:0] exp_neg19;
        logic signed [63:0] exp_neg81;
        int ndone;
`ifdef CNN_CORE_RELU_EN
        exp_neg19 = 0;
        exp_neg81 = 0;
`else
        exp_neg19 = -19;
        exp_neg81 = -81;
`endif
        intf.start = 1'b0;
        set_all(0, 0, 0, 0);
        #12;
        check_val("reset:done", 64'(intf.done), 64'sd0);
        check_val("reset:busy", 64'(intf.busy), 64'sd0);
        check_val("reset:result", 64'(intf.result), 64'sd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_all(1, 1, 1, 0);
        run_op("ones", 81, 1'b0);

        set_all(0, 0, 1, 0);
        for (int n = 0; n < 64; n++) intf.img_flat[n*c_DW +: c_DW] = n;
        intf.kern_flat[4*c_DW +: c_DW] = 1;
        run_op("ramp_center", 324, 1'b0);

        set_all(1, 1, 1, 19);
        run_op("bias_pos", 100, 1'b0);

        set_all(1, 1, 1, -100);
        run_op("bias_neg", exp_neg19, 1'b0);

        set_all(1, -1, 1, 0);
        run_op("kern_neg", exp_neg81, 1'b0);

        // Pool outputs all 9, weights 1..9 -> 9*45.
        set_all(1, 1, 0, 0);
        for (int p = 0; p < 9; p++) intf.fcw_flat[p*c_DW +: c_DW] = p + 1;
        run_op("fcw_ramp", 405, 1'b0);

        set_all(1, 1, 1, 0);
        run_op("restart_ignored", 81, 1'b1);

        set_all(0, 0, 1, 0);
        for (int n = 0; n < 64; n++) intf.img_flat[n*c_DW +: c_DW] = n;
        intf.kern_flat[4*c_DW +: c_DW] = 1;
        run_op("pre_abort", 324, 1'b0);

        set_all(1, 1, 1, 0);
        intf.start = 1'b1;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("abort:done", 64'(intf.done), 64'sd0);
        check_val("abort:busy", 64'(intf.busy), 64'sd0);
        check_val("abort:result", 64'(intf.result), 64'sd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (intf.done) ndone++;
        end
        check_val("abort:no_done", 64'(ndone), 64'sd0);
        check_val("abort:idle_busy", 64'(intf.busy), 64'sd0);

        run_op("after_abort", 81, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/cnn_inference_core.md
Name: cnn_inference_core

Overview:
- Single-channel CNN inference datapath: 8x8 image → 3x3 valid convolution (6x6) → 2x2/stride-2 max pool (3x3) → 9-input fully connected neuron → one scalar.
- Sits under the top-level CNN controller, which pulses start and waits for done.
- Sequential, one result element per clock per stage; fixed, data-independent latency.

Parameters:
- DATA_W, 32, width of every image, weight, bias, intermediate and result word (signed two's complement).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; accepted only in IDLE
- img_flat  in  64*DATA_W  image; pixel n = row*8+col at bits [n*DATA_W +: DATA_W]
- kern_flat  in  9*DATA_W  conv kernel; tap k = i*3+j, same packing
- fcw_flat  in  9*DATA_W  FC weights; weight p pairs with pool output p
- fc_bias  in  DATA_W  FC bias
- busy  out  1  high from start acceptance until done cycle inclusive
- done  out  1  one-cycle pulse; result valid from this cycle onward
- result  out  DATA_W  signed scalar output, held until next done or reset

Behaviour:
- Reset (async, any state): state IDLE, done=0, busy=0, result=0, indices cleared. Reset mid-operation aborts; no done pulse is produced.
- States: IDLE → CONV → POOL → FC → OUT → IDLE.
- Edge E0: start=1 in IDLE. img_flat, kern_flat, fcw_flat, fc_bias are captured into internal registers. Go to CONV, idx=0, busy=1. Inputs may change after E0.
- start while not IDLE: ignored, with no effect on the operation in progress.
- CONV, edges E1..E36: one output per edge, raster order idx=r*6+c.
  - conv[r*6+c] = Σ_{i,j∈0..2} img[(r+i)*8+(c+j)] * kern[i*3+j]. This is correlation, with no kernel flip.
  - Products are full 2*DATA_W signed and summed at full width. The sum is truncated (wrapped) to the low DATA_W bits.
  - At E36 go to POOL.
- POOL, edges E37..E45: pool[pr*3+pc] = signed max of conv at rows 2pr..2pr+1, cols 2pc..2pc+1. Ties are irrelevant. At E45 go to FC.
- FC, edges E46..E54: one MAC per edge, acc += pool[p]*fcw[p] for p=0..8. acc is 2*DATA_W signed, cleared on entering FC. At E54 go to OUT.
- OUT, edge E55:
  - result ← low DATA_W bits of (acc + sign-extended fc_bias), post-processed per Optional Feature.
  - done=1 during the cycle after E55, then done=0.
  - busy drops with done's falling edge. Go to IDLE.
- Latency: done is high exactly 55 clock edges after the accepting edge E0. Back-to-back start is accepted the cycle after done.
- Intermediate conv/pool arrays are internal and not reset-sensitive for correctness. Their contents after reset are don't-care.

Optional Feature:
- Macro CNN_CORE_RELU_EN.
- Defined: result = max(0, wrapped FC sum). Negative sums produce 0.
- Undefined: result = wrapped FC sum, signed, unchanged.
- No other behaviour or timing differs.

Test Plan:
- All img=1, kern=1, fcw=1, bias=0, start at E0 → conv all 9, pool all 9; result=81, done only at E55, busy high E0..done.
- img[n]=n, kern[4]=1 else 0, fcw=1, bias=0 → pool rows {18,20,22},{34,36,38},{50,52,54}; result=324.
- Bias: scenario 1 with bias=19 → result=100. Bias=-100 → result=-19 without RELU_EN, 0 with it.
- img=1, kern=-1, fcw=1, bias=0 → conv/pool all -9; result=-81 (macro off) or 0 (macro on).
- Start re-pulsed at E10 and E30 of an operation → ignored; single done at E55 with correct value. Inputs changed after E0 do not affect result.
- rst asserted asynchronously at E20 → done=0, busy=0, result=0 immediately, no done pulse. A fresh start of scenario 1 then yields 81 at E55.
